stopwatch_ctrl: RTL and testbench
=================================

# stopwatch_ctrl

Synchronous controller that sequences the ripple-carry mm:ss counter chain (mod-10/mod-6/mod-10/mod-6 stages). It converts single-cycle start/stop and lap/clear button pulses into a run/pause/lap/clear state machine. It derives the chain's tick from the system clock via a prescaler and drives the chain's synchronous reset with a correctly framed tick edge. It also selects live or frozen lap time for display and flags an alarm match.

## Interface
- PRESCALE, 100_000_000: system clocks per one-second tick; minimum 4.
- clk  in  1  system clock; all state on posedge.
- rst  in  1  reset, synchronous, active-high.
- start_stop  in  1  single-cycle pulse, already debounced.
- lap_clear  in  1  single-cycle pulse, already debounced.
- time_in  in  16  chain BCD value {min_tens, min_units, sec_tens, sec_units}, asynchronous to clk.
- alarm_val  in  16  BCD alarm time, static while running.
- alarm_en  in  1  enables alarm compare.
- tick  out  1  drives chain clock input; one-clk-wide high pulse.
- chain_rst  out  1  chain synchronous reset.
- disp  out  16  displayed time: live or lap.
- running  out  1  high in RUN and LAP.
- lapped  out  1  high in LAP.
- alarm  out  1  sticky alarm flag.

## Operation
- States: CLR_A, CLR_B, IDLE, RUN, LAP, PAUSE.
- Reset (rst=1): state=CLR_A, tick=0, chain_rst=1, running=0, lapped=0, alarm=0, disp=0, prescaler=0, lap register=0.
- Clear sequence:
  - CLR_A: chain_rst=1, tick=0. Next state is CLR_B.
  - CLR_B: chain_rst=1, tick=1. The chain sees a rising edge while in reset.
  - Next state is IDLE, with chain_rst=0 and tick=0.
  - The clear sequence zeroes the prescaler, the lap register and alarm.
  - Button pulses during CLR_A/CLR_B are ignored.
- Transitions:
  - IDLE: start_stop goes to RUN. lap_clear goes to CLR_A.
  - RUN: start_stop goes to PAUSE. lap_clear captures the synchronized time into the lap register and goes to LAP.
  - LAP: start_stop goes to PAUSE, releasing the freeze. lap_clear goes to RUN, releasing the freeze.
  - PAUSE: start_stop goes to RUN. lap_clear goes to CLR_A.
  - Simultaneous start_stop and lap_clear: start_stop wins; lap_clear is dropped.
- Prescaler:
  - Counts 0..PRESCALE-1 only in RUN/LAP.
  - Holds its value in PAUSE, so the partial second is preserved on resume.
  - tick=1 for exactly the cycle after the prescaler equals PRESCALE-1, while in RUN/LAP; the prescaler wraps to 0.
  - Leaving RUN/LAP on the same cycle as the terminal count still issues that tick.
- time_in sync: two-flop register stage on every clk (time_sync). The chain ripple settles before the second flop is used.
- disp: lap register in LAP; time_sync otherwise.
- Alarm:
  - The compare is evaluated only on the cycle 3 clks after a tick.
  - alarm is set when alarm_en=1 and time_sync==alarm_val.
  - alarm is sticky until the next clear sequence or rst.
  - Chain wrap 59:59 to 00:00 is handled by the chain. The controller has no special case for it.

## Timing
- All outputs are registered.
- Pulse-to-state-change latency is 1 clk: start_stop sampled at cycle n gives running=1 at n+1.
- First tick after IDLE to RUN: PRESCALE clks after the start_stop cycle.
- Subsequent ticks are exactly PRESCALE clks apart while in RUN/LAP.
- disp lag behind time_in: 2 clks (sync) + 1 (output register).
- Lap capture: the lap register holds time_sync as of the lap_clear cycle. disp is frozen from the next cycle.
- Clear from IDLE/PAUSE: lap_clear at n gives CLR_A at n+1, tick high at n+2, IDLE at n+3.
- rst asserted mid-operation overrides everything on the next edge. An in-flight tick is truncated to 0.
- After rst release: CLR_A, then CLR_B, then IDLE.

## Test plan
- PRESCALE=4: rst 2 clks then release → chain_rst=1 for CLR_A/CLR_B, tick high exactly in CLR_B, then IDLE with running=0 and disp=0000.
- start_stop in IDLE → running=1 next clk; ticks at clk offsets 4, 8, 12 after the pulse. Model chain increments; disp=0003 after the third tick + 3 clks.
- RUN, 2 clks into the prescale period, start_stop → PAUSE, no ticks for 20 clks; start_stop again → next tick 2 clks after resume (prescaler held).
- RUN at time 0007, lap_clear → lapped=1, disp frozen at 0007 while the chain advances to 0012; lap_clear → disp tracks live value within 3 clks.
- alarm_val=0005, alarm_en=1: run to 0005 → alarm=1 three clks after the fifth tick, stays 1 past 0006. PAUSE + lap_clear → alarm=0, disp=0000.
- Simultaneous start_stop and lap_clear in RUN → PAUSE, lapped stays 0. rst asserted during the tick cycle → tick=0 next clk, state CLR_A.

Source files
------------

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: sequencer for an external ripple-carry mm:ss BCD counter chain.
//
// Turns single-cycle start_stop / lap_clear pulses into a run/pause/lap/clear
// state machine. It divides clk down to a one-second tick that clocks the chain,
// and it frames the chain's synchronous reset around a tick edge. It also
// selects the live or lap time for display and raises a sticky alarm on a match.
//
// Ports
//   clk        in   system clock, all state on posedge
//   rst        in   synchronous active-high reset
//   start_stop in   start/stop button pulse (debounced, one clk wide)
//   lap_clear  in   lap/clear button pulse (debounced, one clk wide)
//   time_in    in   [15:0] chain BCD {min_tens, min_units, sec_tens, sec_units}, async
//   alarm_val  in   [15:0] BCD alarm time
//   alarm_en   in   alarm compare enable
//   tick       out  chain clock, one-clk-wide high pulse
//   chain_rst  out  chain synchronous reset
//   disp       out  [15:0] displayed time (live or frozen lap)
//   running    out  high in RUN and LAP
//   lapped     out  high in LAP
//   alarm      out  sticky alarm flag
module stopwatch_ctrl #(
    parameter int unsigned PRESCALE = 100_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_stop,
    input  logic        lap_clear,
    input  logic [15:0] time_in,
    input  logic [15:0] alarm_val,
    input  logic        alarm_en,
    output logic        tick,
    output logic        chain_rst,
    output logic [15:0] disp,
    output logic        running,
    output logic        lapped,
    output logic        alarm
);

    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);

    typedef enum logic [2:0] {
        StClrA,
        StClrB,
        StIdle,
        StRun,
        StLap,
        StPause
    } state_e;

    state_e        state_q, state_d;
    logic [PW-1:0] pres_q, pres_d;
    logic [15:0]   lap_q, lap_d;
    logic [15:0]   sync1_q, time_sync_q;
    logic [2:0]    tick_dly_q;
    logic          alarm_q, alarm_d;
    logic          tick_q, tick_d;
    logic          chain_rst_q, chain_rst_d;
    logic          running_q, running_d;
    logic          lapped_q, lapped_d;
    logic [15:0]   disp_q, disp_d;

    logic counting;
    logic pres_term;
    logic clearing;

    // Next-state logic; start_stop has priority over lap_clear everywhere.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StClrA:  state_d = StClrB;
            StClrB:  state_d = StIdle;
            StIdle: begin
                if (start_stop)     state_d = StRun;
                else if (lap_clear) state_d = StClrA;
            end
            StRun: begin
                if (start_stop)     state_d = StPause;
                else if (lap_clear) state_d = StLap;
            end
            StLap: begin
                if (start_stop)     state_d = StPause;
                else if (lap_clear) state_d = StRun;
            end
            StPause: begin
                if (start_stop)     state_d = StRun;
                else if (lap_clear) state_d = StClrA;
            end
            default: state_d = StClrA;
        endcase
    end

    // Datapath next-state and registered output values.
    always_comb begin
        counting    = (state_q == StRun) || (state_q == StLap);
        // Uses the current state, so a terminal count on the cycle we leave
        // RUN/LAP still produces its tick.
        pres_term   = counting && (pres_q == PRE_MAX);
        clearing    = (state_d == StClrA) || (state_d == StClrB);

        pres_d = pres_q;
        if (clearing) begin
            pres_d = '0;
        end else if (counting) begin
            pres_d = pres_term ? '0 : pres_q + 1'b1;
        end

        lap_d = lap_q;
        if (clearing) begin
            lap_d = '0;
        end else if ((state_q == StRun) && (state_d == StLap)) begin
            lap_d = time_sync_q;
        end

        // tick_dly_q[2] marks the edge where time_sync first reflects the
        // chain value produced by the tick three clocks earlier.
        alarm_d = alarm_q;
        if (clearing) begin
            alarm_d = 1'b0;
        end else if (tick_dly_q[2] && alarm_en && (time_sync_q == alarm_val)) begin
            alarm_d = 1'b1;
        end

        // CLR_B tick gives the chain a clock edge while its reset is held.
        tick_d      = pres_term || (state_d == StClrB);
        chain_rst_d = clearing;
        running_d   = (state_d == StRun) || (state_d == StLap);
        lapped_d    = (state_d == StLap);
        disp_d      = (state_d == StLap) ? lap_d : time_sync_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StClrA;
            pres_q      <= '0;
            lap_q       <= '0;
            sync1_q     <= '0;
            time_sync_q <= '0;
            tick_dly_q  <= '0;
            alarm_q     <= 1'b0;
            tick_q      <= 1'b0;
            chain_rst_q <= 1'b1;
            running_q   <= 1'b0;
            lapped_q    <= 1'b0;
            disp_q      <= '0;
        end else begin
            state_q     <= state_d;
            pres_q      <= pres_d;
            lap_q       <= lap_d;
            sync1_q     <= time_in;
            time_sync_q <= sync1_q;
            tick_dly_q  <= {tick_dly_q[1:0], pres_term};
            alarm_q     <= alarm_d;
            tick_q      <= tick_d;
            chain_rst_q <= chain_rst_d;
            running_q   <= running_d;
            lapped_q    <= lapped_d;
            disp_q      <= disp_d;
        end
    end

    assign tick      = tick_q;
    assign chain_rst = chain_rst_q;
    assign disp      = disp_q;
    assign running   = running_q;
    assign lapped    = lapped_q;
    assign alarm     = alarm_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with PRESCALE=4 and a behavioural BCD chain.
module tb_stopwatch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_stop;
    logic        lap_clear;
    logic [15:0] time_in;
    logic [15:0] alarm_val;
    logic        alarm_en;
    logic        tick;
    logic        chain_rst;
    logic [15:0] disp;
    logic        running;
    logic        lapped;
    logic        alarm;

    int nerr = 0;
    int nchk = 0;
    int tick_cnt;

    stopwatch_ctrl #(.PRESCALE(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .start_stop (start_stop),
        .lap_clear  (lap_clear),
        .time_in    (time_in),
        .alarm_val  (alarm_val),
        .alarm_en   (alarm_en),
        .tick       (tick),
        .chain_rst  (chain_rst),
        .disp       (disp),
        .running    (running),
        .lapped     (lapped),
        .alarm      (alarm)
    );

    always #5 clk = ~clk;

    // External mm:ss chain: mod-10 / mod-6 / mod-10 / mod-6, clocked by tick.
    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [3:0] s0, s1, m0, m1;
        s0 = v[3:0]; s1 = v[7:4]; m0 = v[11:8]; m1 = v[15:12];
        if (s0 == 4'd9) begin
            s0 = 4'd0;
            if (s1 == 4'd5) begin
                s1 = 4'd0;
                if (m0 == 4'd9) begin
                    m0 = 4'd0;
                    m1 = (m1 == 4'd5) ? 4'd0 : m1 + 4'd1;
                end else begin
                    m0 = m0 + 4'd1;
                end
            end else begin
                s1 = s1 + 4'd1;
            end
        end else begin
            s0 = s0 + 4'd1;
        end
        return {m1, m0, s1, s0};
    endfunction

    initial time_in = 16'h0000;
    always @(posedge tick) begin
        if (chain_rst) time_in <= 16'h0000;
        else           time_in <= bcd_inc(time_in);
    end

    task automatic tk();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        assert (got === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    initial begin
        rst = 1'b1; start_stop = 1'b0; lap_clear = 1'b0;
        alarm_val = 16'h0000; alarm_en = 1'b0;

        // Reset and clear sequence
        tk(); tk();
        chk("rst_chain_rst", chain_rst, 1);
        chk("rst_tick", tick, 0);
        chk("rst_running", running, 0);
        chk("rst_lapped", lapped, 0);
        chk("rst_alarm", alarm, 0);
        chk("rst_disp", disp, 16'h0000);
        rst = 1'b0;
        tk();
        chk("clrb_chain_rst", chain_rst, 1);
        chk("clrb_tick", tick, 1);
        tk();
        chk("idle_chain_rst", chain_rst, 0);
        chk("idle_tick", tick, 0);
        chk("idle_running", running, 0);
        chk("idle_disp", disp, 16'h0000);

        // Start: ticks at offsets 4, 8, 12
        start_stop = 1'b1; tk(); start_stop = 1'b0;
        chk("start_running", running, 1);
        chk("start_tick", tick, 0);
        for (int i = 1; i <= 12; i++) begin
            tk();
            chk($sformatf("tick_off%0d", i), tick, ((i % 4) == 0) ? 1 : 0);
        end
        tk(); tk();
        chk("disp_lag2", disp, 16'h0002);
        tk();
        chk("disp_lag3", disp, 16'h0003);

        // Pause two clocks into the period; prescaler must hold
        tk();
        chk("tick_off16", tick, 1);
        tk();
        start_stop = 1'b1; tk(); start_stop = 1'b0;
        chk("pause_running", running, 0);
        tick_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            tk();
            if (tick === 1'b1) tick_cnt++;
        end
        chk("pause_no_ticks", tick_cnt, 0);
        chk("pause_disp", disp, 16'h0004);
        start_stop = 1'b1; tk(); start_stop = 1'b0;
        chk("resume_running", running, 1);
        tk();
        chk("resume_tick1", tick, 0);
        tk();
        chk("resume_tick2", tick, 1);

        // Lap at 0007, freeze while chain reaches 0012, then release
        repeat (10) tk();
        chk("prelap_disp", disp, 16'h0006);
        lap_clear = 1'b1; tk(); lap_clear = 1'b0;
        chk("lap_lapped", lapped, 1);
        chk("lap_running", running, 1);
        chk("lap_disp", disp, 16'h0007);
        repeat (20) tk();
        chk("lap_frozen", disp, 16'h0007);
        chk("chain_at_12", time_in, 16'h0012);
        lap_clear = 1'b1; tk(); lap_clear = 1'b0;
        chk("unlap_lapped", lapped, 0);
        chk("unlap_disp", disp, 16'h0012);
        repeat (3) tk();
        chk("unlap_live", disp, 16'h0013);

        // Simultaneous buttons in RUN: start_stop wins
        start_stop = 1'b1; lap_clear = 1'b1; tk();
        start_stop = 1'b0; lap_clear = 1'b0;
        chk("both_running", running, 0);
        chk("both_lapped", lapped, 0);

        // Clear from PAUSE
        lap_clear = 1'b1; tk(); lap_clear = 1'b0;
        chk("clr_a_chain_rst", chain_rst, 1);
        chk("clr_a_tick", tick, 0);
        tk();
        chk("clr_b_tick", tick, 1);
        tk();
        chk("clr_idle_chain_rst", chain_rst, 0);
        tk(); tk();
        chk("clr_disp", disp, 16'h0000);

        // Alarm at 0005
        alarm_val = 16'h0005; alarm_en = 1'b1;
        start_stop = 1'b1; tk(); start_stop = 1'b0;
        repeat (22) tk();
        chk("alarm_pre", alarm, 0);
        tk();
        chk("alarm_set", alarm, 1);
        repeat (5) tk();
        chk("alarm_sticky", alarm, 1);
        chk("alarm_disp6", disp, 16'h0006);
        start_stop = 1'b1; tk(); start_stop = 1'b0;
        chk("alarm_pause", running, 0);
        lap_clear = 1'b1; tk(); lap_clear = 1'b0;
        chk("alarm_cleared", alarm, 0);
        repeat (4) tk();
        chk("alarm_clr_disp", disp, 16'h0000);

        // rst during a tick cycle truncates it
        alarm_en = 1'b0;
        start_stop = 1'b1; tk(); start_stop = 1'b0;
        repeat (4) tk();
        chk("pre_rst_tick", tick, 1);
        rst = 1'b1; tk(); rst = 1'b0;
        chk("rst_trunc_tick", tick, 0);
        chk("rst_trunc_chain_rst", chain_rst, 1);
        chk("rst_trunc_running", running, 0);
        tk();
        chk("rst_trunc_clrb", tick, 1);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
